// File: rtl/v_instr_queue.sv
// v_instr_queue: in-order issue buffer for vector instructions and their scalar operands
module v_instr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_rs1,
  input  logic [XLEN-1:0]          in_rs2,
  output logic                     in_ready,
  output logic                     in_is_vec,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_rs1,
  output logic [XLEN-1:0]          out_rs2,
  input  logic                     deq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OPC_RTYPE = 7'b1010111;
  localparam logic [6:0] OPC_LTYPE = 7'b0000111;
  localparam logic [6:0] OPC_STYPE = 7'b0100111;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_rs1 [DEPTH];
  logic [XLEN-1:0] mem_rs2 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, push, pop;
  // Opcode filter, handshake and empty-masked head presentation
  always_comb begin
    in_is_vec = (in_instr[6:0] == OPC_RTYPE) || (in_instr[6:0] == OPC_LTYPE) || (in_instr[6:0] == OPC_STYPE);
    full      = count == (AW+1)'(DEPTH);
    in_ready  = !full;
    out_valid = count != '0;
    push      = in_valid && in_is_vec && in_ready;
    pop       = deq && out_valid;
    out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    out_rs1   = out_valid ? mem_rs1[rd_ptr] : '0;
    out_rs2   = out_valid ? mem_rs2[rd_ptr] : '0;
  end
  // Entry storage; contents are don't-care while not counted as valid
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_rs1[wr_ptr]   <= in_rs1;
      mem_rs2[wr_ptr]   <= in_rs2;
    end
  end
  // Pointers and occupancy; flush discards any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  // Sticky overflow flag survives flush, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) ovf_err <= 1'b0;
    else if (in_valid && in_is_vec && full) ovf_err <= 1'b1;
  end
endmodule

// File: tb/tb_v_instr_queue.sv
// tb_v_instr_queue: directed checks of filtering, ordering, overflow, wrap, flush and reset
module tb_v_instr_queue;
  logic clk = 0;
  logic rst, flush, in_valid, deq;
  logic [31:0] in_instr, in_rs1, in_rs2;
  logic in_ready, in_is_vec, out_valid, ovf_err;
  logic [31:0] out_instr, out_rs1, out_rs2;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;

  v_instr_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ready(in_ready), .in_is_vec(in_is_vec),
    .out_valid(out_valid), .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .deq(deq), .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vinstr(input int tag);
    logic [6:0] opc;
    opc = (tag % 3 == 0) ? 7'h57 : (tag % 3 == 1) ? 7'h07 : 7'h27;
    return 32'h02000000 | (32'(tag) << 12) | {25'd0, opc};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; deq = 0; flush = 0; rst = 0;
  endtask

  task automatic push(input int tag);
    in_valid = 1; in_instr = vinstr(tag); in_rs1 = 32'(tag); in_rs2 = 32'(tag * 16);
    tick();
    in_valid = 0;
  endtask

  task automatic pop;
    deq = 1;
    tick();
    deq = 0;
  endtask

  task automatic test_reset;
    rst = 1; flush = 0; in_valid = 0; deq = 0; in_instr = 0; in_rs1 = 0; in_rs2 = 0;
    tick(); tick();
    rst = 0;
    checks += 5;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
  endtask

  task automatic test_filter;
    in_valid = 1; in_instr = 32'h00000033; in_rs1 = 32'd9; in_rs2 = 0;
    #1;
    checks++;
    if (in_is_vec !== 1'b0) begin errors++; $display("FAIL filter_is_vec_scalar got %b exp 0", in_is_vec); end
    tick();
    checks += 2;
    if (count !== 3'd0) begin errors++; $display("FAIL filter_scalar_count got %0d exp 0", count); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL filter_scalar_out got %h exp 0", out_instr); end
    in_instr = 32'h0220C0D7; in_rs1 = 32'd5; in_rs2 = 32'd7;
    #1;
    checks++;
    if (in_is_vec !== 1'b1) begin errors++; $display("FAIL filter_is_vec_vadd got %b exp 1", in_is_vec); end
    tick();
    in_valid = 0;
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL filter_out_valid got %b exp 1", out_valid); end
    if (out_instr !== 32'h0220C0D7) begin errors++; $display("FAIL filter_out_instr got %h exp 0220c0d7", out_instr); end
    if (out_rs1 !== 32'd5) begin errors++; $display("FAIL filter_out_rs1 got %0d exp 5", out_rs1); end
    if (out_rs2 !== 32'd7) begin errors++; $display("FAIL filter_out_rs2 got %0d exp 7", out_rs2); end
    if (count !== 3'd1) begin errors++; $display("FAIL filter_count got %0d exp 1", count); end
    pop();
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL filter_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_fill_wrap;
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) push(i + 4 * r);
      checks += 2;
      if (count !== 3'd4) begin errors++; $display("FAIL fill_count[%0d] got %0d exp 4", r, count); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp 0", r, in_ready); end
      push(99);
      checks += 2;
      if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d] got %b exp 1", r, ovf_err); end
      if (count !== 3'd4) begin errors++; $display("FAIL ovf_count[%0d] got %0d exp 4", r, count); end
      for (int i = 1; i <= 4; i++) begin
        checks += 3;
        if (out_rs1 !== 32'(i + 4 * r)) begin errors++; $display("FAIL order_rs1[%0d] got %0d exp %0d", r, out_rs1, i + 4 * r); end
        if (out_rs2 !== 32'((i + 4 * r) * 16)) begin errors++; $display("FAIL order_rs2[%0d] got %0d exp %0d", r, out_rs2, (i + 4 * r) * 16); end
        if (out_instr !== vinstr(i + 4 * r)) begin errors++; $display("FAIL order_instr[%0d] got %h exp %h", r, out_instr, vinstr(i + 4 * r)); end
        pop();
      end
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 0", r, out_valid); end
      if (out_rs1 !== 32'h0) begin errors++; $display("FAIL drain_rs1_zero[%0d] got %0d exp 0", r, out_rs1); end
    end
  endtask

  task automatic test_back_to_back;
    push(40); push(41);
    in_valid = 1; in_instr = vinstr(42); in_rs1 = 32'd42; in_rs2 = 32'd672; deq = 1;
    tick();
    in_valid = 0; deq = 0;
    checks += 2;
    if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
    if (out_rs1 !== 32'd41) begin errors++; $display("FAIL b2b_head got %0d exp 41", out_rs1); end
    pop();
    checks++;
    if (out_rs1 !== 32'd42) begin errors++; $display("FAIL b2b_next got %0d exp 42", out_rs1); end
    pop();
    pop();
    checks += 2;
    if (count !== 3'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_full_deq;
    rst = 1; tick(); rst = 0;
    for (int i = 20; i < 24; i++) push(i);
    in_valid = 1; in_instr = vinstr(24); in_rs1 = 32'd24; in_rs2 = 0; deq = 1;
    tick();
    in_valid = 0; deq = 0;
    checks += 4;
    if (count !== 3'd3) begin errors++; $display("FAIL fulldeq_count got %0d exp 3", count); end
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL fulldeq_ovf got %b exp 1", ovf_err); end
    if (out_rs1 !== 32'd21) begin errors++; $display("FAIL fulldeq_head got %0d exp 21", out_rs1); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fulldeq_ready got %b exp 1", in_ready); end
    pop(); pop();
    checks++;
    if (out_rs1 !== 32'd23) begin errors++; $display("FAIL fulldeq_last got %0d exp 23", out_rs1); end
    pop();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fulldeq_dropped got %b exp 0", out_valid); end
  endtask

  task automatic test_flush;
    push(30); push(31); push(32);
    flush = 1; deq = 1; in_valid = 1; in_instr = vinstr(33); in_rs1 = 32'd33;
    tick();
    flush = 0; deq = 0; in_valid = 0;
    checks += 4;
    if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL flush_out_instr got %h exp 0", out_instr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got %b exp 1", ovf_err); end
    push(34);
    checks++;
    if (out_rs1 !== 32'd34) begin errors++; $display("FAIL flush_restart got %0d exp 34", out_rs1); end
  endtask

  task automatic test_rst_flush;
    push(50);
    rst = 1; flush = 1; in_valid = 1; in_instr = vinstr(51); in_rs1 = 32'd51; deq = 1;
    tick();
    idle();
    checks += 7;
    if (count !== 3'd0) begin errors++; $display("FAIL rstfl_count got %0d exp 0", count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfl_valid got %b exp 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL rstfl_instr got %h exp 0", out_instr); end
    if (out_rs1 !== 32'h0) begin errors++; $display("FAIL rstfl_rs1 got %h exp 0", out_rs1); end
    if (out_rs2 !== 32'h0) begin errors++; $display("FAIL rstfl_rs2 got %h exp 0", out_rs2); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfl_ready got %b exp 1", in_ready); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL rstfl_ovf got %b exp 0", ovf_err); end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_fill_wrap();
    test_back_to_back();
    test_full_deq();
    test_flush();
    test_rst_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
